// File: rtl/bsg_rr_arb_one_hot_mask_pick.sv
// Version tag for the mask-pick logic implemented in bsg_rr_mask_pick.sv.
package bsg_rr_arb_one_hot_mask_pick_pkg;
  localparam int unsigned pick_version = 1;
endpackage

// File: rtl/bsg_rr_arb_pkg.sv
// Shared types for the round-robin one-hot arbiter.
package bsg_rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } rr_arb_state_e;

endpackage

// File: rtl/bsg_rr_mask_pick.sv
// Combinational rotate/first-set/unrotate pick: scans from the slot after
// `last` in the configured direction, checking `last` itself at the end.
module bsg_rr_mask_pick #(
  parameter int width_p    = 4,
  parameter bit lo_to_hi_p = 1'b1,
  localparam int iw_lp     = $clog2(width_p)
) (
  input  logic [width_p-1:0] reqs,
  input  logic [iw_lp-1:0]   last,
  output logic [width_p-1:0] pick,
  output logic               any_v
);

  logic [iw_lp-1:0] idx;
  logic             found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= width_p; k++) begin
      if (lo_to_hi_p) begin
        idx = iw_lp'((int'(last) + k) % width_p);
      end else begin
        idx = iw_lp'((int'(last) + width_p - k) % width_p);
      end
      if (!found && reqs[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign any_v = found;

endmodule

// File: rtl/bsg_rr_arb_one_hot.sv
// Registered round-robin arbiter with sticky one-hot grant.
// Optional burst lock enabled by defining BSG_RR_ARB_LOCK_EN (adds lock_i).
module bsg_rr_arb_one_hot
  import bsg_rr_arb_pkg::*;
#(
  parameter int width_p    = 4,
  parameter bit lo_to_hi_p = 1'b1,
  localparam int iw_lp     = $clog2(width_p)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] reqs_i,
  input  logic               yumi_i,
`ifdef BSG_RR_ARB_LOCK_EN
  input  logic               lock_i,
`endif
  output logic [width_p-1:0] grants_o,
  output logic [iw_lp-1:0]   grant_id_o,
  output logic               v_o,
  output rr_arb_state_e      state_o
);

  // Handshake: v_o/grants_o form a valid that stays asserted and unchanged
  // until the cycle yumi_i is high; yumi_i with v_o low is ignored.

  localparam logic [iw_lp-1:0] last_init_lp =
    lo_to_hi_p ? iw_lp'(width_p - 1) : '0;

  rr_arb_state_e      state_r, state_n;
  logic [width_p-1:0] grant_r, grant_n;
  logic [iw_lp-1:0]   last_r, last_n;
  logic [iw_lp-1:0]   pick_last;
  logic [width_p-1:0] pick;
  logic               pick_v;
  logic               lock_w;
  logic               accept;

`ifdef BSG_RR_ARB_LOCK_EN
  assign lock_w = lock_i;
`else
  assign lock_w = 1'b0;
`endif

  assign accept = (state_r == GRANT) && yumi_i;

  // The accepted index becomes the new pointer in the same cycle it is accepted.
  assign pick_last = (accept && !lock_w) ? grant_id_o : last_r;

  bsg_rr_mask_pick #(
    .width_p   (width_p),
    .lo_to_hi_p(lo_to_hi_p)
  ) u_pick (
    .reqs (reqs_i),
    .last (pick_last),
    .pick (pick),
    .any_v(pick_v)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      grant_r <= '0;
      last_r  <= last_init_lp;
    end else begin
      state_r <= state_n;
      grant_r <= grant_n;
      last_r  <= last_n;
    end
  end

  always_comb begin
    state_n = state_r;
    grant_n = grant_r;
    last_n  = last_r;
    unique case (state_r)
      IDLE: begin
        if (pick_v) begin
          grant_n = pick;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (yumi_i) begin
          last_n = pick_last;
          if (lock_w && reqs_i[grant_id_o]) begin
            grant_n = grant_r;
          end else if (pick_v) begin
            grant_n = pick;
          end else begin
            grant_n = '0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  always_comb begin
    grant_id_o = '0;
    for (int i = 0; i < width_p; i++) begin
      if (grant_r[i]) begin
        grant_id_o = grant_id_o | iw_lp'(i);
      end
    end
  end

  assign grants_o = grant_r;
  assign v_o      = (state_r == GRANT);
  assign state_o  = state_r;

endmodule

// File: tb/tb_bsg_rr_arb_one_hot.sv
// Bench for bsg_rr_arb_one_hot: upward (dut 0) and downward (dut 1) instances
// checked against a behavioural model through an expected-result queue.
module tb_bsg_rr_arb_one_hot;
  import bsg_rr_arb_pkg::*;

  localparam int W  = 4;
  localparam int QW = 1 + W + 2;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] reqs;
  logic         yumi;
  logic         lock;

  logic [W-1:0]  g0, g1;
  logic [1:0]    id0, id1;
  logic          v0, v1;
  rr_arb_state_e st0, st1;

  int n_checks;
  int n_pass;

  logic [QW-1:0] exp_q[$];

  // model state: index 0 scans upward, index 1 downward
  logic         m_v[2];
  logic [W-1:0] m_g[2];
  int           m_last[2];

  bsg_rr_arb_one_hot #(.width_p(W), .lo_to_hi_p(1'b1)) u_dut0 (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .reqs_i    (reqs),
    .yumi_i    (yumi),
`ifdef BSG_RR_ARB_LOCK_EN
    .lock_i    (lock),
`endif
    .grants_o  (g0),
    .grant_id_o(id0),
    .v_o       (v0),
    .state_o   (st0)
  );

  bsg_rr_arb_one_hot #(.width_p(W), .lo_to_hi_p(1'b0)) u_dut1 (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .reqs_i    (reqs),
    .yumi_i    (yumi),
`ifdef BSG_RR_ARB_LOCK_EN
    .lock_i    (lock),
`endif
    .grants_o  (g1),
    .grant_id_o(id1),
    .v_o       (v1),
    .state_o   (st1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [W-1:0] m_pick(input logic [W-1:0] r, input int last, input bit up);
    int idx;
    for (int k = 1; k <= W; k++) begin
      idx = up ? (last + k) % W : (last + W - k) % W;
      if (r[idx]) return W'(1) << idx;
    end
    return '0;
  endfunction

  function automatic int m_id(input logic [W-1:0] g);
    for (int i = 0; i < W; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_v[d]    = 1'b0;
      m_g[d]    = '0;
      m_last[d] = (d == 0) ? W - 1 : 0;
    end
  endtask

  task automatic model_step(input int d, input logic [W-1:0] r, input logic y, input logic lk);
    bit up;
    int cur;
    up = (d == 0);
    if (!m_v[d]) begin
      if (r != 0) begin
        m_g[d] = m_pick(r, m_last[d], up);
        m_v[d] = 1'b1;
      end
    end else if (y) begin
      cur = m_id(m_g[d]);
      if (lk && r[cur]) begin
        // burst continues on the same requester
      end else begin
        if (!lk) m_last[d] = cur;
        m_g[d] = m_pick(r, m_last[d], up);
        if (m_g[d] == 0) m_v[d] = 1'b0;
      end
    end
  endtask

  // driver: apply inputs at negedge, predict, compare one cycle later
  task automatic step(input logic [W-1:0] r, input logic y, input logic lk);
    logic [QW-1:0] e;
    logic          lk_eff;
    @(negedge clk);
    reqs = r;
    yumi = y;
    lock = lk;
`ifdef BSG_RR_ARB_LOCK_EN
    lk_eff = lk;
`else
    lk_eff = 1'b0;
`endif
    for (int d = 0; d < 2; d++) begin
      model_step(d, r, y, lk_eff);
      exp_q.push_back({m_v[d], m_g[d], 2'(m_id(m_g[d]))});
    end
    @(posedge clk);
    #1;
    if (exp_q.size() < 2) begin
      check("sb_empty", 32'(exp_q.size()), 32'd2);
    end else begin
      e = exp_q.pop_front();
      check("d0_v", 32'(v0), 32'(e[QW-1]));
      check("d0_grants", 32'(g0), 32'(e[QW-2:2]));
      check("d0_id", 32'(id0), 32'(e[1:0]));
      e = exp_q.pop_front();
      check("d1_v", 32'(v1), 32'(e[QW-1]));
      check("d1_grants", 32'(g1), 32'(e[QW-2:2]));
      check("d1_id", 32'(id1), 32'(e[1:0]));
    end
  endtask

  task automatic clean_reset();
    @(negedge clk);
    rst_n = 1'b0;
    reqs  = '0;
    yumi  = 1'b0;
    lock  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int exp_up[5];
    int exp_dn[4];
`ifdef BSG_RR_ARB_LOCK_EN
    int exp_lk[5];
`endif
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    reqs  = '0;
    yumi  = 1'b0;
    lock  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_v", 32'(v0), 32'd0);
    check("rst_grants", 32'(g0), 32'd0);
    check("rst_id", 32'(id0), 32'd0);
    check("rst_state", 32'(st0), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // full request, accept every cycle
    exp_up = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b1, 1'b0);
      check("rr_seq_id", 32'(id0), 32'(exp_up[i]));
      check("rr_seq_v", 32'(v0), 32'd1);
    end
    step(4'b0000, 1'b1, 1'b0);
    check("rr_drain_v", 32'(v0), 32'd0);

    // sticky grant
    for (int i = 0; i < 6; i++) step(4'b0100, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(4'b0001, 1'b0, 1'b0);
      check("sticky_grants", 32'(g0), 32'h4);
    end
    step(4'b0001, 1'b1, 1'b0);
    check("sticky_next", 32'(g0), 32'h1);
    step(4'b0000, 1'b1, 1'b0);

    // asynchronous reset while granting index 2
    clean_reset();
    step(4'b0100, 1'b0, 1'b0);
    check("pre_rst_id", 32'(id0), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_v", 32'(v0), 32'd0);
    check("async_rst_grants", 32'(g0), 32'd0);
    check("async_rst_v1", 32'(v1), 32'd0);
    #1 rst_n = 1'b1;
    model_reset();
    step(4'b0110, 1'b0, 1'b0);
    check("post_rst_id", 32'(id0), 32'd1);

    // downward search
    clean_reset();
    exp_dn = '{3, 0, 3, 0};
    for (int i = 0; i < 4; i++) begin
      step(4'b1001, 1'b1, 1'b0);
      check("dn_seq_id", 32'(id1), 32'(exp_dn[i]));
    end
    step(4'b0000, 1'b1, 1'b0);

    // single requester, no bubble, then drop at an accept
    for (int i = 0; i < 4; i++) begin
      step(4'b0100, 1'b1, 1'b0);
      if (i > 0) begin
        check("single_id", 32'(id0), 32'd2);
        check("single_v", 32'(v0), 32'd1);
      end
    end
    step(4'b0000, 1'b1, 1'b0);
    check("single_drop_v", 32'(v0), 32'd0);

`ifdef BSG_RR_ARB_LOCK_EN
    clean_reset();
    exp_lk = '{0, 0, 0, 0, 1};
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b1, (i >= 1 && i <= 3));
      check("lock_seq_id", 32'(id0), 32'(exp_lk[i]));
    end
    step(4'b0000, 1'b1, 1'b0);
`endif

    // random traffic
    clean_reset();
    for (int i = 0; i < 300; i++) begin
      step(W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
